// File: rtl/example_mix_pkg.sv
// example_mix_pkg: shared nibble-mix encoding used by both the mixer and demixer sides.
package example_mix_pkg;

    typedef logic [3:0] nibble_t;

    typedef struct packed {
        nibble_t a;
        nibble_t b;
    } pair_t;

    typedef enum logic {WAIT0, WAIT1} dmx_state_e;

    // A[0]/A[2] and A[1]/A[3] share a slot in beat0/beat1 respectively; same for B[2]/B[0], B[3]/B[1].
    localparam int POS_A_EVEN = 3;
    localparam int POS_A_ODD  = 1;
    localparam int POS_B_EVEN = 2;
    localparam int POS_B_ODD  = 0;

    function automatic nibble_t mix_beat0(input nibble_t a, input nibble_t b);
        nibble_t r;
        r             = '0;
        r[POS_A_EVEN] = a[0];
        r[POS_A_ODD]  = a[1];
        r[POS_B_EVEN] = b[2];
        r[POS_B_ODD]  = b[3];
        return r;
    endfunction

    function automatic nibble_t mix_beat1(input nibble_t a, input nibble_t b);
        nibble_t r;
        r             = '0;
        r[POS_A_EVEN] = a[2];
        r[POS_A_ODD]  = a[3];
        r[POS_B_EVEN] = b[0];
        r[POS_B_ODD]  = b[1];
        return r;
    endfunction

    function automatic pair_t demix(input nibble_t b0, input nibble_t b1);
        pair_t p;
        p.a = {b1[POS_A_ODD], b1[POS_A_EVEN], b0[POS_A_ODD], b0[POS_A_EVEN]};
        p.b = {b0[POS_B_ODD], b0[POS_B_EVEN], b1[POS_B_ODD], b1[POS_B_EVEN]};
        return p;
    endfunction

endpackage

// File: rtl/example_demix_map.sv
// example_demix_map: combinational beat0/beat1 -> {A, B} unscrambling.
module example_demix_map
    import example_mix_pkg::*;
(
    input  logic [3:0] b0_i,
    input  logic [3:0] b1_i,
    output logic [3:0] a_o,
    output logic [3:0] b_o
);

    pair_t p;

    assign p   = demix(b0_i, b1_i);
    assign a_o = p.a;
    assign b_o = p.b;

endmodule

// File: rtl/example_demixer.sv
// example_demixer: reassembles {A, B} pairs from a two-beat mixed nibble stream.
module example_demixer
    import example_mix_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int PAIR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [3:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_a,
    output logic [3:0]        out_b,
    output logic              sync_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [PAIR_W-1:0] pair_cnt
);

    dmx_state_e        state_q, state_d;
    nibble_t           lo_q, lo_d, a_q, a_d, b_q, b_d, map_a, map_b;
    logic              vld_q, vld_d, err_q, err_d, xfer, load;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PAIR_W-1:0] pcnt_q, pcnt_d;

    example_demix_map u_map (
        .b0_i (lo_q),
        .b1_i (in_data),
        .a_o  (map_a),
        .b_o  (map_b)
    );

    // beat0 always has a home in lo_q; beat1 needs room in the output register
    always_comb begin
        in_ready = (state_q == WAIT0) || !vld_q || out_ready;
        xfer     = in_valid && in_ready;
        load     = xfer && (state_q == WAIT1) && !in_sof;
        err_d    = xfer && (in_sof == (state_q == WAIT1));
        state_d  = xfer ? (in_sof ? WAIT1 : WAIT0) : state_q;
        lo_d     = (xfer && in_sof) ? in_data : lo_q;
        a_d      = load ? map_a : a_q;
        b_d      = load ? map_b : b_q;
        vld_d    = load || (vld_q && !out_ready);
        cnt_d    = (err_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        pcnt_d   = (vld_q && out_ready) ? pcnt_q + 1'b1 : pcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign out_valid = vld_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign sync_err  = err_q;
    assign err_cnt   = cnt_q;
    assign pair_cnt  = pcnt_q;

endmodule

// File: tb/tb_example_demixer.sv
// tb_example_demixer: directed scoreboard bench for the demixer and its map.
module tb_example_demixer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready, out_valid, sync_err;
    logic [3:0]  out_a, out_b;
    logic [7:0]  err_cnt;
    logic [15:0] pair_cnt;
    logic [3:0]  m_b0 = '0, m_b1 = '0, m_a, m_b;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    logic       rnd_ready = 1'b0;
    logic       stall_seen = 1'b0;
    logic [7:0] stall_val = '0;

    example_demixer #(.CNT_W(8), .PAIR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .out_b(out_b), .sync_err(sync_err), .err_cnt(err_cnt), .pair_cnt(pair_cnt)
    );

    example_demix_map u_map (.b0_i(m_b0), .b1_i(m_b1), .a_o(m_a), .b_o(m_b));

    always #5 clk = ~clk;

    function automatic logic [3:0] enc0(input logic [3:0] a, input logic [3:0] b);
        return {a[0], b[2], a[1], b[3]};
    endfunction

    function automatic logic [3:0] enc1(input logic [3:0] a, input logic [3:0] b);
        return {a[2], b[0], a[3], b[1]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sof, input logic [3:0] d);
        int w = 0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("beat_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic push);
        if (push) sb.push_back({a, b});
        beat(1'b1, enc0(a, b));
        beat(1'b0, enc1(a, b));
    endtask

    // Scoreboard monitor: pops on every delivered pair, checks holding during stalls
    always @(negedge clk) begin
        if (rst) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen) chk("stall_hold", {out_valid, out_a, out_b}, {1'b1, stall_val});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_pair", {out_a, out_b}, 9'h100);
                else chk("pair", {out_a, out_b}, sb.pop_front());
            end
            stall_seen <= out_valid && !out_ready;
            stall_val  <= {out_a, out_b};
        end
    end

    always @(posedge clk) if (rnd_ready) #1 out_ready = 1'($urandom_range(0, 1));

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_b0 = enc0(i[7:4], i[3:0]);
            m_b1 = enc1(i[7:4], i[3:0]);
            #1;
            chk("map_a", m_a, i[7:4]);
            chk("map_b", m_b, i[3:0]);
        end
        tick(3);
        rst = 1'b0;
        chk("rst_out", {out_valid, out_a, out_b, sync_err}, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnts", {err_cnt, pair_cnt}, 0);
        out_ready = 1'b1;
        send_pair(4'hA, 4'h6, 1'b1);
        chk("basic_valid", out_valid, 1);
        tick(1);
        chk("basic_pair_cnt", pair_cnt, 1);
        chk("basic_drained", out_valid, 0);
        out_ready = 1'b0;
        send_pair(4'hF, 4'h0, 1'b1);
        sb.push_back({4'hA, 4'h6});
        beat(1'b1, 4'h6);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_data  = 4'h3;
        tick(3);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out", {out_valid, out_a, out_b}, {1'b1, 8'hF0});
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("stall_reload", {out_valid, out_a, out_b}, {1'b1, 8'hA6});
        tick(1);
        chk("stall_pair_cnt", pair_cnt, 3);
        beat(1'b0, 4'h5);
        chk("stray_pulse", {sync_err, err_cnt}, {1'b1, 8'd1});
        chk("stray_no_out", out_valid, 0);
        tick(1);
        chk("stray_pulse_end", sync_err, 0);
        sb.push_back({4'hA, 4'h6});
        beat(1'b1, 4'h3);
        beat(1'b1, 4'h6);
        chk("resync_pulse", {sync_err, err_cnt}, {1'b1, 8'd2});
        beat(1'b0, 4'h3);
        chk("resync_quiet", {sync_err, err_cnt}, {1'b0, 8'd2});
        tick(1);
        chk("resync_pair_cnt", pair_cnt, 4);
        repeat (300) beat(1'b0, 4'h0);
        chk("err_saturate", err_cnt, 8'hFF);
        out_ready = 1'b0;
        send_pair(4'h3, 4'h9, 1'b0);
        beat(1'b1, 4'h7);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_out", {out_valid, out_a, out_b, sync_err}, 0);
        chk("async_rst_cnts", {err_cnt, pair_cnt}, 0);
        tick(1);
        rst = 1'b0;
        out_ready = 1'b1;
        send_pair(4'h5, 4'hC, 1'b1);
        chk("post_rst_out", {out_valid, out_a, out_b}, {1'b1, 8'h5C});
        tick(1);
        chk("post_rst_cnts", {err_cnt, pair_cnt}, {8'd0, 16'd1});
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 256; i++) send_pair(i[7:4], i[3:0], 1'b1);
        rnd_ready = 1'b0;
        tick(1);
        out_ready = 1'b1;
        for (int w = 0; w < 20 && sb.size() != 0; w++) tick(1);
        chk("exh_drained", sb.size(), 0);
        tick(1);
        chk("exh_pair_cnt", pair_cnt, 256);
        chk("exh_err_cnt", err_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/example_demixer.md
Name: example_demixer

Overview:
- Receive side of the nibble-mix interface: reassembles two 4-bit operands A and B from a stream of mixed nibbles.
- The sender transmits each operand pair as two beats:
  - beat0 = {A[0], B[2], A[1], B[3]}
  - beat1 = {A[2], B[0], A[3], B[1]}
- Sits downstream of the mixing stage on a valid/ready link. Delivers registered {A, B} pairs on a second valid/ready link and counts framing errors.

Parameters:
- CNT_W, 8, width of the saturating framing-error counter.
- PAIR_W, 16, width of the wrapping completed-pair counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_ready  output  1  demixer accepts a beat this cycle.
- in_sof  input  1  marks beat0 of a pair.
- in_data  input  4  mixed nibble.
- out_valid  output  1  out_a/out_b hold a complete pair.
- out_ready  input  1  downstream accepts the pair.
- out_a  output  4  reconstructed A.
- out_b  output  4  reconstructed B.
- sync_err  output  1  one-cycle pulse on a framing error.
- err_cnt  output  CNT_W  saturating count of framing errors.
- pair_cnt  output  PAIR_W  count of pairs delivered (out_valid && out_ready); wraps.

Behaviour:
- Reset (async assert, sync release): all outputs and state are 0; state = WAIT0.
- Storage:
  - lo_q (4b): beat0 holding register.
  - out register: out_a, out_b, out_valid.
- States:
  - WAIT0: no beat0 held.
  - WAIT1: beat0 held in lo_q.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - A pair transfers when out_valid && out_ready.
  - out_a/out_b are stable while out_valid && !out_ready.
- in_ready:
  - WAIT0: 1 (beat0 lands in lo_q regardless of the out register).
  - WAIT1: !out_valid || out_ready.
- WAIT0 transitions:
  - Transfer with in_sof = 1: lo_q <= in_data; go to WAIT1.
  - Transfer with in_sof = 0: drop the beat, pulse sync_err, err_cnt += 1; stay in WAIT0.
- WAIT1 transitions:
  - Transfer with in_sof = 0 (beat1), with b0 = lo_q and b1 = in_data:
    - out_a <= {b1[1], b1[3], b0[1], b0[3]}
    - out_b <= {b0[0], b0[2], b1[0], b1[2]}
    - out_valid <= 1; go to WAIT0.
  - Transfer with in_sof = 1: discard old lo_q, pulse sync_err, err_cnt += 1; lo_q <= in_data; stay in WAIT1.
    - Because in_ready in WAIT1 requires output space, a resync beat can stall. This is accepted.
- Latency: pair visible on out_* the cycle after the beat1 transfer.
- Back-to-back: a new pair loads in the same cycle the old pair transfers. Full throughput is one pair per two input cycles.
- out_valid clears on a pair transfer unless a new pair loads in the same cycle.
- err_cnt saturates at all-ones. sync_err pulses exactly once per errored beat.
- pair_cnt increments on each pair transfer and wraps at 2^PAIR_W.
- in_data is don't-care when in_valid = 0. No state changes without a transfer.
- Reset mid-pair: held beat0 and any undelivered pair are lost; err_cnt clears.

Decomposition:
- Package example_mix_pkg:
  - Constants for the beat0/beat1 bit positions of each A/B bit.
  - Nibble typedef.
  - Pure functions mix_beat0(a, b), mix_beat1(a, b), demix(b0, b1), shared with the mixer side.
- Sub-module example_demix_map: the combinational b0/b1 -> {a, b} mapping, instantiated once so the bench can test it exhaustively on its own.
- FSM, counters and handshake live in example_demixer.

Test Plan:
- Basic pair: A=4'b1010, B=4'b0110 sent as beat0 4'b0110 (sof=1), then beat1 4'b0011 (sof=0), out_ready=1 -> next cycle out_valid=1, out_a=4'hA, out_b=4'h6; pair_cnt=1.
- Stall: A=4'hF, B=4'h0 (beats 4'hA, 4'hA) with out_ready=0, then a second pair is offered -> out_a/out_b held; beat0 accepted; in_ready=0 in WAIT1. Raise out_ready -> first pair transfers, second pair loads the same cycle.
- Stray beat1: in_sof=0 while in WAIT0 -> beat dropped, sync_err=1 for one cycle, err_cnt=1, no out_valid.
- Resync: beat0 (sof=1, 4'h3), then another sof=1 (4'h6), then beat1 4'h3 -> sync_err once, err_cnt=1, output built from 4'h6 and 4'h3 (A=4'hA, B=4'h6).
- Saturation/reset: 300 stray beats with CNT_W=8 -> err_cnt=8'hFF. Assert rst mid-pair -> all outputs 0 immediately (async); the next correct pair decodes cleanly.
- Exhaustive: all 256 {A, B} sent back-to-back with random out_ready -> every output matches the package demix, pair_cnt=256, err_cnt=0.
